aes128_round_sequencer: RTL and testbench

//  Iterative AES-128 encryption engine controller: sequences one full AES round per clock

---
 rtl/aes128_round_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_aes128_round_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one full round per clock through a shared datapath,
// with valid/ready handshakes on the block/key input and the ciphertext output.

package aes128_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, zero maps to zero) plus the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

module aes_sbox
    import aes128_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);
    assign y = sbox(a);
endmodule

module aes_mixcolumns
    import aes128_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);
    logic [7:0] s0, s1, s2, s3;

    assign {s0, s1, s2, s3} = col;
    assign mixed[31:24] = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    assign mixed[23:16] = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    assign mixed[15:8]  = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    assign mixed[7:0]   = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
endmodule

module aes128_round_sequencer
    import aes128_pkg::*;
#(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [3:0]   round_idx
);

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, rkey_q;
    logic [3:0]   rnd_q;
    logic         accept;

    logic [7:0]   sub_b [16];
    logic [127:0] sr, mc, round_out;
    logic [31:0]  rot_w, key_sub, key_tmp;
    logic [31:0]  nk0, nk1, nk2, nk3;

    assign accept    = in_valid & in_ready;
    assign round_idx = rnd_q;

    // SubBytes, then ShiftRows: byte (r,c) takes the byte from column (c+r) mod 4.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        aes_sbox u_sbox (.a(state_q[127-8*i -: 8]), .y(sub_b[i]));
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sub_b[4*((c+r)%4)+r];
            end
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mixcolumns u_mix (.col(sr[127-32*c -: 32]), .mixed(mc[127-32*c -: 32]));
    end

    // On-the-fly key expansion: RotWord/SubWord on the last word, rcon by round.
    assign rot_w = {rkey_q[23:0], rkey_q[31:24]};
    for (genvar j = 0; j < 4; j++) begin : g_key
        aes_sbox u_ksbox (.a(rot_w[31-8*j -: 8]), .y(key_sub[31-8*j -: 8]));
    end

    assign key_tmp = key_sub ^ {rcon(rnd_q), 24'h0};
    assign nk0 = rkey_q[127:96] ^ key_tmp;
    assign nk1 = rkey_q[95:64] ^ nk0;
    assign nk2 = rkey_q[63:32] ^ nk1;
    assign nk3 = rkey_q[31:0] ^ nk2;

    assign round_out = ((rnd_q == 4'd10) ? sr : mc) ^ {nk0, nk1, nk2, nk3};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (accept) fsm_d = ROUND;
            ROUND:   if (rnd_q == 4'd10) fsm_d = DONE;
            DONE:    if (out_ready) fsm_d = accept ? ROUND : IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_block = '0;
        case (fsm_q)
            IDLE:  in_ready = !rst;
            ROUND: busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                out_block = state_q;
                in_ready  = BACK_TO_BACK && out_ready && !rst;
            end
            default: ;
        endcase
    end

    // Datapath only moves on an accept or a round edge; DONE holds the ciphertext.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            rkey_q  <= '0;
            rnd_q   <= '0;
        end else if (accept) begin
            state_q <= in_block ^ in_key;
            rkey_q  <= in_key;
            rnd_q   <= 4'd1;
        end else if (fsm_q == ROUND) begin
            state_q <= round_out;
            rkey_q  <= {nk0, nk1, nk2, nk3};
            rnd_q   <= (rnd_q == 4'd10) ? 4'd0 : rnd_q + 4'd1;
        end
    end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: known-answer vectors through a scoreboard,
// plus backpressure, back-to-back, mid-round reset and input-gating sequences.

module tb_aes128_round_sequencer;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [3:0]   round_idx;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] tb_exp;
    logic [127:0] sb [$];
    vec_t         vecs [5];

    always #5 clk = ~clk;

    aes128_round_sequencer #(.BACK_TO_BACK(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .round_idx (round_idx)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on the input handshake, pop and compare on the output handshake.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, want no output", out_block);
                end else begin
                    check("ciphertext", out_block, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(tb_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a block and return just after the accepting edge.
    task automatic send(input logic [127:0] key, input logic [127:0] pt,
                        input logic [127:0] ct, input bit hold);
        int n = 0;
        in_key   = key;
        in_block = pt;
        tb_exp   = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("accept_ready", 128'(in_ready), 128'd1);
        step();
        if (!hold) in_valid = 1'b0;
    endtask

    // Count clock edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int n);
        n = 0;
        do begin
            step();
            n++;
            if (n == 4) begin
                check("mid_round_idx", 128'(round_idx), 128'd5);
                check("mid_busy", 128'(busy), 128'd1);
            end
        end while (!out_valid && n < 100);
        check("out_valid_seen", 128'(out_valid), 128'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, n2, bad;

        vecs[0] = '{key: C1_KEY, pt: C1_PT, ct: C1_CT};
        vecs[1] = '{key: B_KEY,  pt: B_PT,  ct: B_CT};
        vecs[2] = '{key: 128'h0, pt: 128'h0, ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{key: B_KEY,  pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                    ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[4] = '{key: B_KEY,  pt: 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                    ct: 128'hf5d3d58503b9699de785895a96fdbaaf};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        in_key    = '0;
        tb_exp    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'd1);
        check("post_rst_out_valid", 128'(out_valid), 128'd0);
        check("post_rst_busy", 128'(busy), 128'd0);
        check("post_rst_round_idx", 128'(round_idx), 128'd0);
        check("post_rst_out_block", out_block, 128'd0);

        // Known-answer table with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].key, vecs[i].pt, vecs[i].ct, 1'b0);
            wait_out(n);
            check("latency", 128'(n), 128'd10);
            step();
            check("post_handshake_valid", 128'(out_valid), 128'd0);
            check("idle_in_ready", 128'(in_ready), 128'd1);
        end

        // Backpressure: result must hold and nothing new may enter.
        out_ready = 1'b0;
        send(C1_KEY, C1_PT, C1_CT, 1'b0);
        wait_out(n);
        check("bp_latency", 128'(n), 128'd10);
        in_key   = vecs[2].key;
        in_block = vecs[2].pt;
        tb_exp   = vecs[2].ct;
        in_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            step();
            if (out_valid !== 1'b1 || out_block !== C1_CT || in_ready !== 1'b0 ||
                busy !== 1'b0 || round_idx !== 4'd0) bad++;
        end
        check("bp_stable", 128'(bad), 128'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", 128'(out_valid), 128'd0);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);

        // Back-to-back: second block accepted on the first output's handshake edge.
        send(B_KEY, B_PT, B_CT, 1'b1);
        in_key   = C1_KEY;
        in_block = C1_PT;
        tb_exp   = C1_CT;
        wait_out(n);
        check("b2b_first_latency", 128'(n), 128'd10);
        check("b2b_in_ready", 128'(in_ready), 128'd1);
        step();
        in_valid = 1'b0;
        check("b2b_second_busy", 128'(busy), 128'd1);
        check("b2b_second_round_idx", 128'(round_idx), 128'd1);
        wait_out(n2);
        check("b2b_spacing", 128'(n2 + 1), 128'd11);
        step();
        check("b2b_done_valid", 128'(out_valid), 128'd0);

        // Input gating: activity on in_valid/in_block during ROUND must be ignored.
        send(B_KEY, B_PT, B_CT, 1'b0);
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (in_ready !== 1'b0) bad++;
            in_valid = k[0];
            in_block = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            tb_exp   = {$urandom, $urandom, $urandom, $urandom};
        end
        in_valid = 1'b0;
        check("gate_in_ready", 128'(bad), 128'd0);
        n = 8;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        check("gate_latency", 128'(n), 128'd10);
        step();

        // Reset in the middle of round 5 aborts the block.
        send(C1_KEY, C1_PT, C1_CT, 1'b0);
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin
            step();
            n++;
        end
        check("pre_reset_round_idx", 128'(round_idx), 128'd5);
        rst = 1'b1;
        step();
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_round_idx", 128'(round_idx), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd0);
        check("abort_out_block", out_block, 128'd0);
        sb.delete();
        rst = 1'b0;
        bad = 0;
        repeat (12) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        check("abort_no_output", 128'(bad), 128'd0);
        send(C1_KEY, C1_PT, C1_CT, 1'b0);
        wait_out(n);
        check("after_reset_latency", 128'(n), 128'd10);
        step();

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
